rv32i_ctrl_decoder: RTL and testbench
=====================================

// Module: rv32i_ctrl_decoder
// PURPOSE
//  Main control decoder of the single-cycle RV32I datapath. Combinationally decodes the
//  instruction word and the branch-comparator flags into datapath selects: PC mux,
//  immediate format, ALU operand and operation, memory R/W, register write, writeback
//  source and load/store width. A single sticky register records illegal encodings.
// PARAMETERS
//  none
// PORTS
//  clk_i        in   1   clock; used only by the sticky illegal flag
//  rst_i        in   1   reset, synchronous, active-high
//  inst_i       in   32  instruction word
//  BrEq         in   1   comparator: rs1 == rs2
//  BrLT         in   1   comparator: rs1 < rs2 (signedness per BrUn_o)
//  imm_sel_o    out  5   one-hot imm format: I=00001 S=00010 B=00100 U=01000 J=10000
//  alu_sel_o    out  4   ALU op; R/I: {inst[30],funct3}; 0000=ADD; 1001=pass B (LUI)
//  pc_sel_o     out  1   1 = next PC from ALU (taken branch/jump); 0 = PC+4
//  regWEn_o     out  1   register-file write enable
//  BrUn_o       out  1   1 = unsigned compare
//  a_sel_o      out  1   ALU A: 0=rs1, 1=PC
//  b_sel_o      out  1   ALU B: 0=rs2, 1=immediate
//  memRW_o      out  1   1 = data-memory write
//  wb_sel_o     out  2   00=mem, 01=ALU, 10=PC+4, 11 unused
//  ld_st_sel_o  out  3   access width/sign = funct3 (inst[14:12])
//  illegal_o    out  1   sticky: an undecodable instruction was presented
// BEHAVIOUR
//  - Clock: clk_i; reset rst_i is synchronous, active-high. All decode outputs are purely
//    combinational (zero latency) and ignore clk_i/rst_i.
//  - Decode keys: opc=inst[6:2] (inst[1:0] ignored), f3=inst[14:12], f7b=inst[30].
//  - Defaults for unlisted fields: BrUn_o=f3[1], a_sel_o=0, wb_sel_o=01,
//    ld_st_sel_o=f3, imm_sel_o=00001.
//  - R 01100: a0 b1->b0, alu={f7b,f3}, regWEn1, wb01. f7b=1 legal only for f3=000/101.
//  - I-ALU 00100: imm I, b1, regWEn1, wb01; alu={0,f3}, except f3=001/101 use {f7b,f3};
//    SLLI with f7b=1 is illegal.
//  - Load 00000: imm I, b1, alu0000, regWEn1, wb00; f3 in {000,001,010,100,101} else illegal.
//  - Store 01000: imm S, b1, alu0000, memRW1, regWEn0; f3 in {000,001,010} else illegal.
//  - Branch 11000: imm B, a1, b1, alu0000, regWEn0, memRW0, BrUn=f3[1].
//    pc_sel: BEQ(000)=BrEq, BNE(001)=!BrEq, BLT/BLTU(100/110)=BrLT, BGE/BGEU(101/111)=!BrLT.
//    f3=010/011 illegal.
//  - JAL 11011: pc_sel1, imm J, a1, b1, alu0000, regWEn1, wb10.
//  - JALR 11001: pc_sel1, imm I, a0, b1, alu0000, regWEn1, wb10.
//  - LUI 01101: imm U, b1, alu1001, regWEn1, wb01.
//  - AUIPC 00101: imm U, a1, b1, alu0000, regWEn1, wb01.
//  - Illegal (any other opc/combination): pc_sel0, regWEn0, memRW0, alu0000, others default;
//    illegal_o set on next clk_i edge and held until rst_i. Reset value illegal_o=0;
//    rst_i wins over a simultaneous illegal decode.
//  - All non-branch instructions: pc_sel_o = 1 only for JAL/JALR; memRW_o = 1 only for stores.
// STRUCTURE
//  - Shared package rv32i_pkg: opcode constants, imm_sel one-hot, alu_sel codes, wb_sel codes.
//  - Single module, one always_comb decode case on opc + one always_ff for illegal_o;
//    branch-resolve logic may be split into sub-module branch_resolve.
// TESTING
//  - ADD/SUB: opc 01100 f3 000, f7b 0/1 -> alu 0000/1000, b0, regWEn1, wb01, pc_sel0.
//  - SRAI f3 101 f7b1 -> imm 00001, b1, alu 1101; SLLI f7b1 -> all enables 0, illegal_o=1 next cycle.
//  - LHU f3 101 -> wb00, ld_st 101, regWEn1; SW f3 010 -> imm 00010, memRW1, regWEn0.
//  - Sweep all 8 branch f3 x {BrEq,BrLT}: BGE BrLT=0 -> pc_sel1; BLTU -> BrUn1; BEQ BrEq=0 -> pc_sel0.
//  - JAL -> pc_sel1 imm 10000 a1 wb10; LUI -> imm 01000 b1 alu 1001 wb01; AUIPC -> a1 alu 0000.
//  - Exhaustive 2048-vector sweep of {BrLT,BrEq,inst[30],f3,opc}; then rst_i=1 one cycle -> illegal_o=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I control constants: opcode keys (inst[6:2]), one-hot
// immediate formats, ALU select codes and writeback source codes.
package rv32i_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    typedef enum logic [4:0] {
        IMM_I = 5'b00001,
        IMM_S = 5'b00010,
        IMM_B = 5'b00100,
        IMM_U = 5'b01000,
        IMM_J = 5'b10000
    } imm_sel_e;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_PASSB = 4'b1001;

    typedef enum logic [1:0] {
        WB_MEM = 2'b00,
        WB_ALU = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

endpackage

// File: rtl/rv32i_ctrl_decoder_branch_resolve.sv
// Branch resolution: maps funct3 and comparator flags to taken/not-taken.
// Ports: f3_i, br_eq_i, br_lt_i in; taken_o, valid_o (f3 is a real branch) out.
module branch_resolve (
    input  logic [2:0] f3_i,
    input  logic       br_eq_i,
    input  logic       br_lt_i,
    output logic       taken_o,
    output logic       valid_o
);

    always_comb begin
        taken_o = 1'b0;
        valid_o = 1'b1;
        case (f3_i)
            3'b000:          taken_o = br_eq_i;
            3'b001:          taken_o = ~br_eq_i;
            3'b100, 3'b110:  taken_o = br_lt_i;
            3'b101, 3'b111:  taken_o = ~br_lt_i;
            default:         valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_ctrl_decoder.sv
// Main control decoder of a single-cycle RV32I datapath; all selects are
// combinational from inst_i/BrEq/BrLT, only illegal_o is a (sticky) flop.
module rv32i_ctrl_decoder
    import rv32i_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] inst_i,
    input  logic        BrEq,
    input  logic        BrLT,
    output logic [4:0]  imm_sel_o,
    output logic [3:0]  alu_sel_o,
    output logic        pc_sel_o,
    output logic        regWEn_o,
    output logic        BrUn_o,
    output logic        a_sel_o,
    output logic        b_sel_o,
    output logic        memRW_o,
    output logic [1:0]  wb_sel_o,
    output logic [2:0]  ld_st_sel_o,
    output logic        illegal_o
);

    logic [4:0] opc;
    logic [2:0] f3;
    logic       f7b;
    logic       br_taken;
    logic       br_valid;
    logic       ill;
    logic       illegal_d;
    logic       illegal_q;
    logic       unused_bits;

    assign opc = inst_i[6:2];
    assign f3  = inst_i[14:12];
    assign f7b = inst_i[30];

    // Only the decode keys matter; remaining instruction bits are don't-care.
    assign unused_bits = ^{inst_i[31], inst_i[29:15],
                           inst_i[11:7], inst_i[1:0]};

    branch_resolve u_branch_resolve (
        .f3_i    (f3),
        .br_eq_i (BrEq),
        .br_lt_i (BrLT),
        .taken_o (br_taken),
        .valid_o (br_valid)
    );

    always_comb begin
        imm_sel_o   = IMM_I;
        alu_sel_o   = ALU_ADD;
        pc_sel_o    = 1'b0;
        regWEn_o    = 1'b0;
        BrUn_o      = f3[1];
        a_sel_o     = 1'b0;
        b_sel_o     = 1'b0;
        memRW_o     = 1'b0;
        wb_sel_o    = WB_ALU;
        ld_st_sel_o = f3;
        ill         = 1'b0;
        case (opc)
            OPC_OP: begin
                regWEn_o  = 1'b1;
                alu_sel_o = {f7b, f3};
                // inst[30] only selects SUB and SRA
                ill = f7b & (f3 != 3'b000) & (f3 != 3'b101);
            end
            OPC_OPIMM: begin
                b_sel_o   = 1'b1;
                regWEn_o  = 1'b1;
                // inst[30] is part of the immediate except for shifts
                if (f3 == 3'b001 || f3 == 3'b101)
                    alu_sel_o = {f7b, f3};
                else
                    alu_sel_o = {1'b0, f3};
                ill = f7b & (f3 == 3'b001);
            end
            OPC_LOAD: begin
                b_sel_o  = 1'b1;
                regWEn_o = 1'b1;
                wb_sel_o = WB_MEM;
                ill = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
            end
            OPC_STORE: begin
                imm_sel_o = IMM_S;
                b_sel_o   = 1'b1;
                memRW_o   = 1'b1;
                ill       = f3[2] | (f3[1:0] == 2'b11);
            end
            OPC_BRANCH: begin
                imm_sel_o = IMM_B;
                a_sel_o   = 1'b1;
                b_sel_o   = 1'b1;
                pc_sel_o  = br_taken;
                ill       = ~br_valid;
            end
            OPC_JAL: begin
                imm_sel_o = IMM_J;
                pc_sel_o  = 1'b1;
                a_sel_o   = 1'b1;
                b_sel_o   = 1'b1;
                regWEn_o  = 1'b1;
                wb_sel_o  = WB_PC4;
            end
            OPC_JALR: begin
                pc_sel_o = 1'b1;
                b_sel_o  = 1'b1;
                regWEn_o = 1'b1;
                wb_sel_o = WB_PC4;
            end
            OPC_LUI: begin
                imm_sel_o = IMM_U;
                b_sel_o   = 1'b1;
                alu_sel_o = ALU_PASSB;
                regWEn_o  = 1'b1;
            end
            OPC_AUIPC: begin
                imm_sel_o = IMM_U;
                a_sel_o   = 1'b1;
                b_sel_o   = 1'b1;
                regWEn_o  = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        // Undecodable words must not change architectural state.
        if (ill) begin
            imm_sel_o = IMM_I;
            alu_sel_o = ALU_ADD;
            pc_sel_o  = 1'b0;
            regWEn_o  = 1'b0;
            a_sel_o   = 1'b0;
            b_sel_o   = 1'b0;
            memRW_o   = 1'b0;
            wb_sel_o  = WB_ALU;
        end
    end

    assign illegal_d = illegal_q | ill;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            illegal_q <= 1'b0;
        else
            illegal_q <= illegal_d;
    end

    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_rv32i_ctrl_decoder.sv
// Self-checking bench for rv32i_ctrl_decoder: directed cases plus a full
// sweep of the decode keys, expected values queued from a reference model.
module tb_rv32i_ctrl_decoder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] inst_i = 32'h0;
    logic        BrEq = 1'b0;
    logic        BrLT = 1'b0;
    logic [4:0]  imm_sel_o;
    logic [3:0]  alu_sel_o;
    logic        pc_sel_o;
    logic        regWEn_o;
    logic        BrUn_o;
    logic        a_sel_o;
    logic        b_sel_o;
    logic        memRW_o;
    logic [1:0]  wb_sel_o;
    logic [2:0]  ld_st_sel_o;
    logic        illegal_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [19:0] ctl;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    logic sticky = 1'b0;

    rv32i_ctrl_decoder dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inst_i      (inst_i),
        .BrEq        (BrEq),
        .BrLT        (BrLT),
        .imm_sel_o   (imm_sel_o),
        .alu_sel_o   (alu_sel_o),
        .pc_sel_o    (pc_sel_o),
        .regWEn_o    (regWEn_o),
        .BrUn_o      (BrUn_o),
        .a_sel_o     (a_sel_o),
        .b_sel_o     (b_sel_o),
        .memRW_o     (memRW_o),
        .wb_sel_o    (wb_sel_o),
        .ld_st_sel_o (ld_st_sel_o),
        .illegal_o   (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference decode; returns {ctl fields, illegal-this-word}
    function automatic exp_t model(input logic [31:0] ins,
                                   input logic eq, input logic lt);
        logic [4:0] opc, imm;
        logic [2:0] f3;
        logic [3:0] alu;
        logic [1:0] wb;
        logic f7, pc, rw, a, b, mem, bad;
        exp_t r;
        opc = ins[6:2]; f3 = ins[14:12]; f7 = ins[30];
        imm = 5'b00001; alu = 4'b0000; wb = 2'b01;
        pc = 0; rw = 0; a = 0; b = 0; mem = 0; bad = 0;
        if (opc == 5'b01100) begin
            bad = f7 && !(f3 == 3'd0 || f3 == 3'd5);
            rw = 1; alu = {f7, f3};
        end else if (opc == 5'b00100) begin
            bad = f7 && f3 == 3'd1;
            rw = 1; b = 1;
            alu = (f3 == 3'd1 || f3 == 3'd5) ? {f7, f3} : {1'b0, f3};
        end else if (opc == 5'b00000) begin
            bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            rw = 1; b = 1; wb = 2'b00;
        end else if (opc == 5'b01000) begin
            bad = f3 > 3'd2;
            imm = 5'b00010; b = 1; mem = 1;
        end else if (opc == 5'b11000) begin
            imm = 5'b00100; a = 1; b = 1;
            bad = (f3 == 3'd2 || f3 == 3'd3);
            if (f3 == 3'd0) pc = eq;
            if (f3 == 3'd1) pc = !eq;
            if (f3 == 3'd4 || f3 == 3'd6) pc = lt;
            if (f3 == 3'd5 || f3 == 3'd7) pc = !lt;
        end else if (opc == 5'b11011) begin
            pc = 1; imm = 5'b10000; a = 1; b = 1; rw = 1; wb = 2'b10;
        end else if (opc == 5'b11001) begin
            pc = 1; b = 1; rw = 1; wb = 2'b10;
        end else if (opc == 5'b01101) begin
            imm = 5'b01000; b = 1; alu = 4'b1001; rw = 1;
        end else if (opc == 5'b00101) begin
            imm = 5'b01000; a = 1; b = 1; rw = 1;
        end else begin
            bad = 1;
        end
        if (bad) begin
            imm = 5'b00001; alu = 0; pc = 0; rw = 0;
            a = 0; b = 0; mem = 0; wb = 2'b01;
        end
        r.ctl = {imm, alu, pc, rw, f3[1], a, b, mem, wb, f3};
        r.ill = bad;
        return r;
    endfunction

    // Build a word from its decode keys; all other bits random.
    function automatic logic [31:0] mk(input logic [4:0] opc,
                                       input logic [2:0] f3,
                                       input logic f7);
        logic [31:0] w;
        w = $urandom;
        w[6:2] = opc;
        w[14:12] = f3;
        w[30] = f7;
        return w;
    endfunction

    task automatic drive(input string tag, input logic [31:0] ins,
                         input logic eq, input logic lt, input logic rst);
        exp_t e, p;
        @(negedge clk_i);
        inst_i = ins; BrEq = eq; BrLT = lt; rst_i = rst;
        e = model(ins, eq, lt);
        e.ill = rst ? 1'b0 : (sticky | e.ill);
        sticky = e.ill;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        p = exp_q.pop_front();
        check({tag, "_ctl"}, 32'({imm_sel_o, alu_sel_o, pc_sel_o,
              regWEn_o, BrUn_o, a_sel_o, b_sel_o, memRW_o,
              wb_sel_o, ld_st_sel_o}), 32'(p.ctl));
        check({tag, "_ill"}, 32'(illegal_o), 32'(p.ill));
    endtask

    initial begin
        logic [10:0] v;
        drive("reset", 32'h0000_0003, 1'b0, 1'b0, 1'b1);
        check("reset_illegal", 32'(illegal_o), 32'd0);

        drive("add", mk(5'b01100, 3'd0, 1'b0), 1'b0, 1'b0, 1'b0);
        check("add_alu", 32'(alu_sel_o), 32'h0);
        check("add_pc", 32'(pc_sel_o), 32'd0);
        drive("sub", mk(5'b01100, 3'd0, 1'b1), 1'b0, 1'b0, 1'b0);
        check("sub_alu", 32'(alu_sel_o), 32'h8);
        check("sub_b", 32'(b_sel_o), 32'd0);
        drive("srai", mk(5'b00100, 3'd5, 1'b1), 1'b0, 1'b0, 1'b0);
        check("srai_alu", 32'(alu_sel_o), 32'hd);
        drive("lhu", mk(5'b00000, 3'd5, 1'b0), 1'b0, 1'b0, 1'b0);
        check("lhu_wb", 32'(wb_sel_o), 32'd0);
        drive("sw", mk(5'b01000, 3'd2, 1'b0), 1'b0, 1'b0, 1'b0);
        check("sw_mem", 32'(memRW_o), 32'd1);
        drive("jal", mk(5'b11011, 3'd0, 1'b0), 1'b0, 1'b0, 1'b0);
        check("jal_imm", 32'(imm_sel_o), 32'h10);
        drive("lui", mk(5'b01101, 3'd0, 1'b0), 1'b0, 1'b0, 1'b0);
        check("lui_alu", 32'(alu_sel_o), 32'h9);
        drive("auipc", mk(5'b00101, 3'd0, 1'b0), 1'b0, 1'b0, 1'b0);
        check("auipc_a", 32'(a_sel_o), 32'd1);
        drive("jalr", mk(5'b11001, 3'd0, 1'b0), 1'b0, 1'b0, 1'b0);

        for (int f = 0; f < 8; f++)
            for (int c = 0; c < 4; c++)
                drive("br", mk(5'b11000, 3'(f), 1'b0),
                      c[0], c[1], 1'b0);
        check("br_sticky_clear", 32'(illegal_o), 32'd1);

        drive("rst2", mk(5'b00100, 3'd1, 1'b1), 1'b0, 1'b0, 1'b1);
        check("rst_wins", 32'(illegal_o), 32'd0);
        drive("bge_nt", mk(5'b11000, 3'd5, 1'b0), 1'b0, 1'b0, 1'b0);
        check("bge_pc", 32'(pc_sel_o), 32'd1);
        drive("bltu", mk(5'b11000, 3'd6, 1'b0), 1'b0, 1'b1, 1'b0);
        check("bltu_un", 32'(BrUn_o), 32'd1);
        drive("beq_ne", mk(5'b11000, 3'd0, 1'b0), 1'b0, 1'b0, 1'b0);
        check("beq_pc", 32'(pc_sel_o), 32'd0);
        check("legal_no_flag", 32'(illegal_o), 32'd0);
        drive("slli_bad", mk(5'b00100, 3'd1, 1'b1), 1'b0, 1'b0, 1'b0);
        check("slli_reg", 32'(regWEn_o), 32'd0);
        check("slli_flag", 32'(illegal_o), 32'd1);
        drive("held", mk(5'b01100, 3'd0, 1'b0), 1'b0, 1'b0, 1'b0);
        check("held_flag", 32'(illegal_o), 32'd1);

        drive("rst3", 32'h0000_0003, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2048; i++) begin
            v = 11'(i);
            drive("sweep", mk(v[4:0], v[7:5], v[8]), v[9], v[10], 1'b0);
        end
        drive("rst_end", mk(5'b11111, 3'd0, 1'b0), 1'b0, 1'b0, 1'b1);
        check("final_reset", 32'(illegal_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
